book_delta_serializer: RTL and testbench

//  Downstream consumer of Order_Book. On each orderbook_ready pulse, snapshots all bid/ask levels and

---
 rtl/md_book_pkg.sv | 39 +++
 rtl/book_delta_out_reg.sv | 36 +++
 rtl/book_delta_serializer.sv | 167 ++++++++++++++++
 tb/tb_book_delta_serializer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_book_pkg.sv
// Package md_book_pkg: shared types and constants for the book delta serializer.
//   level_t  : one book level {price, quantity, num_orders} (88 bits)
//   state_t  : serializer FSM states
//   hdr_beat / trail_beat : 64-bit beat formatters
package md_book_pkg;

  localparam int unsigned DEPTH   = 10;
  localparam int unsigned LEVEL_W = 88;
  localparam int unsigned OUT_W   = 64;
  localparam int unsigned SLOTS   = 2 * DEPTH;

  localparam logic [7:0] TAG_HDR   = 8'hA5;
  localparam logic [7:0] TAG_TRAIL = 8'h5E;

  typedef struct packed {
    logic [63:0] price;
    logic [15:0] quantity;
    logic [7:0]  num_orders;
  } level_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SCAN,
    S_HDR,
    S_PRICE,
    S_TRAIL
  } state_t;

  function automatic logic [63:0] hdr_beat(input logic side, input logic [3:0] lvl,
                                           input level_t l);
    return {TAG_HDR, 3'b000, side, lvl, l.num_orders, l.quantity, 24'h0};
  endfunction

  function automatic logic [63:0] trail_beat(input logic [7:0] cnt, input logic [31:0] seq);
    return {TAG_TRAIL, 8'h00, cnt, 8'h00, seq};
  endfunction

endpackage

// File: rtl/book_delta_out_reg.sv
// book_delta_out_reg: 64-bit registered output slice with valid/ready hold.
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture load_data as a new beat (only when empty or accepting)
//   load_data   : next beat payload
//   out_ready   : consumer ready
//   out_data    : registered beat payload, stable while stalled
//   out_valid   : registered beat-present flag
//   accept      : out_valid && out_ready (beat consumed this cycle)
module book_delta_out_reg
  import md_book_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             accept
);

  assign accept = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/book_delta_serializer.sv
// book_delta_serializer: on each orderbook_ready pulse, snapshots the bid/ask book,
// compares it slot by slot with the last published book and emits only changed levels
// (HDR + PRICE beats), followed by a TRAIL beat carrying change count and sequence number.
//   clk, reset       : clock, synchronous active-high reset
//   orderbook_ready  : 1-cycle pulse, book inputs valid
//   bid_levels       : DEPTH bid levels, level i at [i*LEVEL_W +: LEVEL_W]
//   ask_levels       : DEPTH ask levels, same layout
//   out_data/out_valid/out_ready : 64-bit beat stream with valid/ready handshake
//   busy             : high from capture until trailer accepted
//   overrun_cnt      : coalesced-pulse counter, present only with BOOK_DELTA_STATS_EN defined
module book_delta_serializer
  import md_book_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     orderbook_ready,
  input  logic [DEPTH*LEVEL_W-1:0] bid_levels,
  input  logic [DEPTH*LEVEL_W-1:0] ask_levels,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
`ifdef BOOK_DELTA_STATS_EN
  ,output logic [15:0]             overrun_cnt
`endif
);

  state_t      state;
  logic [4:0]  slot;
  logic [7:0]  changed_cnt;
  logic [31:0] seq;
  logic        pending;
  level_t      snap   [SLOTS];
  level_t      shadow [SLOTS];

  logic        accept;
  logic        load;
  logic [63:0] load_data;
  logic        slot_changed;
  logic        last_slot;
  logic        side;
  logic [3:0]  lvl;

  assign slot_changed = (snap[slot] != shadow[slot]);
  assign last_slot    = (slot == 5'(SLOTS - 1));
  assign side         = (slot >= 5'(DEPTH));
  assign lvl          = 4'(side ? slot - 5'(DEPTH) : slot);

  // Next beat is loaded on the same edge the FSM enters HDR/PRICE/TRAIL,
  // so out_valid is registered without a bubble cycle.
  always_comb begin
    load      = 1'b0;
    load_data = '0;
    case (state)
      S_SCAN: begin
        if (slot_changed) begin
          load      = 1'b1;
          load_data = hdr_beat(side, lvl, snap[slot]);
        end else if (last_slot) begin
          load      = 1'b1;
          load_data = trail_beat(changed_cnt, seq);
        end
      end
      S_HDR: begin
        if (accept) begin
          load      = 1'b1;
          load_data = snap[slot].price;
        end
      end
      S_PRICE: begin
        // Trailer count includes the level being accepted this cycle.
        if (accept && last_slot) begin
          load      = 1'b1;
          load_data = trail_beat(8'(changed_cnt + 8'd1), seq);
        end
      end
      default: ;
    endcase
  end

  book_delta_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .accept    (accept)
  );

  always_ff @(posedge clk) begin
    if (state == S_CAPTURE) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        snap[i]         <= bid_levels[i*LEVEL_W +: LEVEL_W];
        snap[i + DEPTH] <= ask_levels[i*LEVEL_W +: LEVEL_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      slot        <= '0;
      changed_cnt <= '0;
      seq         <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) shadow[i] <= '0;
    end else begin
      if (orderbook_ready && state != S_IDLE) pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (orderbook_ready || pending) begin
            state   <= S_CAPTURE;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        S_CAPTURE: begin
          slot        <= '0;
          changed_cnt <= '0;
          state       <= S_SCAN;
        end
        S_SCAN: begin
          if (slot_changed)   state <= S_HDR;
          else if (last_slot) state <= S_TRAIL;
          else                slot  <= slot + 5'd1;
        end
        S_HDR: begin
          if (accept) state <= S_PRICE;
        end
        S_PRICE: begin
          if (accept) begin
            shadow[slot] <= snap[slot];
            changed_cnt  <= changed_cnt + 8'd1;
            if (last_slot) begin
              state <= S_TRAIL;
            end else begin
              slot  <= slot + 5'd1;
              state <= S_SCAN;
            end
          end
        end
        S_TRAIL: begin
          if (accept) begin
            seq   <= seq + 32'd1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BOOK_DELTA_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_cnt <= '0;
    end else if (orderbook_ready && (busy || pending) && overrun_cnt != '1) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_book_delta_serializer.sv
// Self-checking bench for book_delta_serializer. Expected beat streams come from a
// frame-level model: compare each level of the book with the last published copy.
module tb_book_delta_serializer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         orderbook_ready = 1'b0;
  logic [879:0] bid_levels = '0;
  logic [879:0] ask_levels = '0;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
`ifdef BOOK_DELTA_STATS_EN
  logic [15:0]  overrun_cnt;
`endif

  always #5 clk = ~clk;

  book_delta_serializer dut (
    .clk             (clk),
    .reset           (reset),
    .orderbook_ready (orderbook_ready),
    .bid_levels      (bid_levels),
    .ask_levels      (ask_levels),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy)
`ifdef BOOK_DELTA_STATS_EN
    ,.overrun_cnt    (overrun_cnt)
`endif
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [87:0] bid_m [10];
  logic [87:0] ask_m [10];
  logic [87:0] shadow_m [20];
  logic [31:0] seq_m;
  logic [63:0] exp_q [$];
  logic [63:0] got_q [$];
  int unsigned stall_errs;
  bit          timed_out;

  function automatic logic [87:0] mk_level(input logic [63:0] px, input logic [15:0] qty,
                                           input logic [7:0] n);
    return {px, qty, n};
  endfunction

  function automatic logic [87:0] rand_level();
    if ($urandom_range(0, 3) == 0) return '0;
    return {$urandom, $urandom, 16'($urandom), 8'($urandom)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 20; i++) shadow_m[i] = '0;
    seq_m = '0;
  endfunction

  function automatic void clear_book();
    for (int i = 0; i < 10; i++) begin
      bid_m[i] = '0;
      ask_m[i] = '0;
    end
  endfunction

  // One published frame: every level differing from the last published book, bids then asks.
  function automatic void model_frame();
    logic [87:0] cur;
    logic        side;
    logic [3:0]  lvl;
    logic [7:0]  cnt;
    exp_q.delete();
    cnt = '0;
    for (int s = 0; s < 20; s++) begin
      side = (s >= 10);
      lvl  = 4'(s % 10);
      cur  = side ? ask_m[s - 10] : bid_m[s];
      if (cur !== shadow_m[s]) begin
        exp_q.push_back({8'hA5, 3'b000, side, lvl, cur[7:0], cur[23:8], 24'h0});
        exp_q.push_back(cur[87:24]);
        shadow_m[s] = cur;
        cnt++;
      end
    end
    exp_q.push_back({8'h5E, 8'h00, cnt, 8'h00, seq_m});
    seq_m++;
  endfunction

  task automatic drive_book();
    for (int i = 0; i < 10; i++) begin
      bid_levels[i*88 +: 88] = bid_m[i];
      ask_levels[i*88 +: 88] = ask_m[i];
    end
  endtask

  task automatic pulse();
    drive_book();
    orderbook_ready = 1'b1;
    @(posedge clk); #1;
    orderbook_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    orderbook_ready = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Accepts beats until a trailer is consumed; records stall-hold violations.
  task automatic collect(input bit rand_ready);
    bit          prev_stall;
    bit          done;
    bit          want_price;
    logic [63:0] prev_data;
    got_q.delete();
    stall_errs = 0;
    timed_out  = 1'b1;
    prev_stall = 1'b0;
    prev_data  = '0;
    done       = 1'b0;
    want_price = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_errs++;
      out_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (want_price)                    want_price = 1'b0;
        else if (out_data[63:56] == 8'hA5) want_price = 1'b1;
        else if (out_data[63:56] == 8'h5E) done = 1'b1;
      end
      @(posedge clk); #1;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got %0b expected 0", out_valid);
    end
    vectors++;
    if (out_data !== 64'h0) begin
      miscompares++; $display("FAIL reset_data got %h expected 0", out_data);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %0b expected 0", busy);
    end
`ifdef BOOK_DELTA_STATS_EN
    vectors++;
    if (overrun_cnt !== 16'h0) begin
      miscompares++; $display("FAIL reset_overrun got %0d expected 0", overrun_cnt);
    end
`endif
  endtask

  task automatic test_single_level();
    clear_book();
    bid_m[0] = mk_level(64'hAE, 16'd9, 8'd1);
    model_frame();
    out_ready = 1'b1;
    pulse();
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL t1_early_valid got %0b expected 0", out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++; $display("FAIL t1_latency got %0b expected 1", out_valid);
    end
    collect(1'b0);
    vectors++;
    if (got_q.size() != 3 || timed_out) begin
      miscompares++; $display("FAIL t1_count got %0d expected 3 (timeout %0b)", got_q.size(), timed_out);
    end else begin
      vectors += 3;
      if (got_q[0] !== 64'hA500010009000000) begin
        miscompares++; $display("FAIL t1_hdr got %h expected a500010009000000", got_q[0]);
      end
      if (got_q[1] !== 64'hAE) begin
        miscompares++; $display("FAIL t1_price got %h expected ae", got_q[1]);
      end
      if (got_q[2] !== 64'h5E00010000000000) begin
        miscompares++; $display("FAIL t1_trail got %h expected 5e00010000000000", got_q[2]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL t1_model beat %0d got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL t1_busy_end got %0b expected 0", busy);
    end
  endtask

  task automatic test_heartbeat();
    model_frame();
    pulse();
    collect(1'b1);
    vectors++;
    if (got_q.size() != 1 || timed_out) begin
      miscompares++; $display("FAIL t2_count got %0d expected 1 (timeout %0b)", got_q.size(), timed_out);
    end else begin
      vectors += 2;
      if (got_q[0] !== 64'h5E00000000000001) begin
        miscompares++; $display("FAIL t2_trail got %h expected 5e00000000000001", got_q[0]);
      end
      if (got_q[0] !== exp_q[0]) begin
        miscompares++; $display("FAIL t2_model got %h expected %h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_clear_and_order();
    ask_m[3] = mk_level(64'h100, 16'd5, 8'd2);
    model_frame();
    pulse();
    collect(1'b0);
    vectors++;
    if (got_q.size() != exp_q.size() || timed_out) begin
      miscompares++; $display("FAIL t3a_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    ask_m[3] = mk_level(64'h100, 16'd0, 8'd2);
    bid_m[9] = mk_level(64'h1234, 16'd7, 8'd3);
    model_frame();
    pulse();
    collect(1'b1);
    vectors++;
    if (got_q.size() != 5 || timed_out) begin
      miscompares++; $display("FAIL t3_count got %0d expected 5 (timeout %0b)", got_q.size(), timed_out);
    end else begin
      vectors += 4;
      if (got_q[0][63:48] !== 16'hA509) begin
        miscompares++; $display("FAIL t3_bid9_first got %h expected a509", got_q[0][63:48]);
      end
      if (got_q[2][63:48] !== 16'hA513) begin
        miscompares++; $display("FAIL t3_ask3_second got %h expected a513", got_q[2][63:48]);
      end
      if (got_q[2][39:24] !== 16'h0) begin
        miscompares++; $display("FAIL t3_ask3_qty got %h expected 0", got_q[2][39:24]);
      end
      if (got_q[4][47:40] !== 8'd2) begin
        miscompares++; $display("FAIL t3_trail_cnt got %0d expected 2", got_q[4][47:40]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL t3_model beat %0d got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_stall();
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) begin
        if ($urandom_range(0, 1) == 1) bid_m[$urandom_range(0, 9)] = rand_level();
        else                           ask_m[$urandom_range(0, 9)] = rand_level();
      end
      model_frame();
      pulse();
      collect(1'b1);
      vectors += 2;
      if (timed_out || got_q.size() != exp_q.size()) begin
        miscompares++; $display("FAIL t4_count frame %0d got %0d expected %0d", f, got_q.size(), exp_q.size());
      end
      if (stall_errs != 0) begin
        miscompares++; $display("FAIL t4_stall_hold frame %0d got %0d violations expected 0", f, stall_errs);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL t4_beat frame %0d beat %0d got %h expected %h", f, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    clear_book();
    bid_m[$urandom_range(0, 9)] = {$urandom, $urandom, 16'($urandom), 8'($urandom)} | 88'h1;
    model_frame();
    out_ready = 1'b0;
    pulse();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      ask_m[$urandom_range(0, 9)] = rand_level();
      bid_m[$urandom_range(0, 9)] = rand_level();
      pulse();
    end
    collect(1'b1);
    vectors++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL t5_first_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL t5_first beat %0d got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    model_frame();
    collect(1'b1);
    vectors++;
    if (timed_out || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL t5_second_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL t5_second beat %0d got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL t5_no_third_frame got busy %0b valid %0b expected 0 0", busy, out_valid);
    end
`ifdef BOOK_DELTA_STATS_EN
    vectors++;
    if (overrun_cnt !== 16'd3) begin
      miscompares++; $display("FAIL t5_overrun got %0d expected 3", overrun_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int unsigned waited;
    do_reset();
    clear_book();
    bid_m[0] = {$urandom, $urandom, 16'($urandom), 8'($urandom)} | 88'h1;
    bid_m[4] = mk_level(64'h55, 16'd3, 8'd1);
    ask_m[7] = mk_level(64'hDEAD, 16'd0, 8'd0);
    model_frame();
    out_ready = 1'b0;
    pulse();
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    vectors++;
    if (!out_valid) begin
      miscompares++; $display("FAIL t6_hdr_timeout got valid 0 expected 1");
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== bid_m[0][87:24]) begin
      miscompares++; $display("FAIL t6_price_beat got %h expected %h", out_data, bid_m[0][87:24]);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL t6_abort got valid %0b busy %0b expected 0 0", out_valid, busy);
    end
    reset = 1'b0;
    model_reset();
    model_frame();
    pulse();
    collect(1'b1);
    vectors++;
    if (timed_out || got_q.size() != 7) begin
      miscompares++; $display("FAIL t6_count got %0d expected 7", got_q.size());
    end else begin
      vectors++;
      if (got_q[6] !== 64'h5E00030000000000) begin
        miscompares++; $display("FAIL t6_trail got %h expected 5e00030000000000", got_q[6]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL t6_beat %0d got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    clear_book();
    model_reset();
    test_reset();
    test_single_level();
    test_heartbeat();
    test_clear_and_order();
    test_random_stall();
    test_coalesce();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
